loopback_seq: RTL and testbench

// Line-copy sequencer sitting directly upstream of the DMA memory controller, on its CPU-side word port.

---
 rtl/loopback_seq.sv | 211 +++++++++++++++++++++
 tb/tb_loopback_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_seq.sv
// loopback_seq: line-copy sequencer in front of the DMA memory controller's word port.
// Each line is read word-by-word from src into a local line buffer, then written back
// word-by-word to dst.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   start            1-cycle pulse that begins a copy (ignored while busy)
//   src_base         first source line address (sampled on accepted start)
//   dst_base         first destination line address (sampled on accepted start)
//   num_lines        number of lines to copy (sampled on accepted start)
//   busy             high from accepted start until done
//   done             1-cycle pulse at end of copy
//   err              sticky short-read flag, cleared by the next accepted start
//   lines_done       lines fully written in the current/last copy
//   mc_ready         controller has left startup
//   mc_rd_valid      controller read word valid
//   mc_tx_done       controller last-word / write-complete pulse
//   mc_rd_word       controller read word
//   mc_op            registered op: 00 IDLE, 01 READ, 11 WRITE
//   mc_raw_address   registered line address
//   mc_wr_word       write word, buf[wr_idx] (combinational)
module loopback_seq #(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64,
  parameter int ADDR_STRIDE   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_BITCOUNT-1:0] src_base,
  input  logic [ADDR_BITCOUNT-1:0] dst_base,
  input  logic [15:0]              num_lines,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [15:0]              lines_done,
  input  logic                     mc_ready,
  input  logic                     mc_rd_valid,
  input  logic                     mc_tx_done,
  input  logic [WORD_SIZE-1:0]     mc_rd_word,
  output logic [1:0]               mc_op,
  output logic [ADDR_BITCOUNT-1:0] mc_raw_address,
  output logic [WORD_SIZE-1:0]     mc_wr_word
);

  localparam int FILL_COUNT = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int IDX_W      = (FILL_COUNT > 1) ? $clog2(FILL_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILL_COUNT - 1);

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RD, S_R2W, S_WR, S_W2R
  } state_t;

  state_t                   state, state_nxt;
  logic [1:0]               op_nxt;
  logic [ADDR_BITCOUNT-1:0] addr_nxt;
  logic [ADDR_BITCOUNT-1:0] src_q, src_nxt, dst_q, dst_nxt;
  logic [15:0]              num_q, num_nxt, lines_nxt;
  logic                     busy_nxt, done_nxt, err_nxt;
  logic [IDX_W-1:0]         rd_idx, rd_idx_nxt, wr_idx, wr_idx_nxt;
  logic                     wr_first, wr_first_nxt;
  logic                     buf_we;
  logic [WORD_SIZE-1:0]     line_buf [FILL_COUNT];
  logic [ADDR_BITCOUNT-1:0] line_offset;

  // Line offset wraps modulo the address width.
  assign line_offset = ADDR_BITCOUNT'(lines_done) * ADDR_BITCOUNT'(ADDR_STRIDE);
  assign mc_wr_word  = line_buf[wr_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FILL_COUNT; i++) line_buf[i] <= '0;
    end else if (buf_we) begin
      line_buf[rd_idx] <= mc_rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      mc_op          <= OP_IDLE;
      mc_raw_address <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      num_q          <= '0;
      lines_done     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rd_idx         <= '0;
      wr_idx         <= '0;
      wr_first       <= 1'b0;
    end else begin
      state          <= state_nxt;
      mc_op          <= op_nxt;
      mc_raw_address <= addr_nxt;
      src_q          <= src_nxt;
      dst_q          <= dst_nxt;
      num_q          <= num_nxt;
      lines_done     <= lines_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      err            <= err_nxt;
      rd_idx         <= rd_idx_nxt;
      wr_idx         <= wr_idx_nxt;
      wr_first       <= wr_first_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    op_nxt       = mc_op;
    addr_nxt     = mc_raw_address;
    src_nxt      = src_q;
    dst_nxt      = dst_q;
    num_nxt      = num_q;
    lines_nxt    = lines_done;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;
    rd_idx_nxt   = rd_idx;
    wr_idx_nxt   = wr_idx;
    wr_first_nxt = wr_first;
    buf_we       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          src_nxt   = src_base;
          dst_nxt   = dst_base;
          num_nxt   = num_lines;
          lines_nxt = '0;
          err_nxt   = 1'b0;
          // An empty copy completes without ever touching the controller.
          if (num_lines == 16'd0) begin
            done_nxt = 1'b1;
          end else begin
            busy_nxt  = 1'b1;
            state_nxt = S_INIT;
          end
        end
      end

      S_INIT: begin
        if (mc_ready) begin
          op_nxt    = OP_READ;
          addr_nxt  = src_q + line_offset;
          state_nxt = S_RD;
        end
      end

      S_RD: begin
        // The final word arrives together with mc_tx_done, so capture on either.
        if (mc_rd_valid || mc_tx_done) buf_we = 1'b1;
        if (mc_tx_done) begin
          if (rd_idx != LAST_IDX) err_nxt = 1'b1;
          rd_idx_nxt = '0;
          op_nxt     = OP_IDLE;
          state_nxt  = S_R2W;
        end else if (mc_rd_valid) begin
          rd_idx_nxt = rd_idx + 1'b1;
        end
      end

      // One idle cycle keeps the controller from relaunching the read.
      S_R2W: begin
        op_nxt       = OP_WRITE;
        addr_nxt     = dst_q + line_offset;
        wr_idx_nxt   = '0;
        wr_first_nxt = 1'b1;
        state_nxt    = S_WR;
      end

      // The controller spends the first WR cycle accepting the op, so the index
      // only starts advancing afterwards; fill cycle k then sees buf[k].
      S_WR: begin
        if (mc_tx_done) begin
          op_nxt       = OP_IDLE;
          lines_nxt    = lines_done + 1'b1;
          wr_idx_nxt   = '0;
          wr_first_nxt = 1'b0;
          state_nxt    = S_W2R;
        end else if (wr_first) begin
          wr_first_nxt = 1'b0;
        end else if (wr_idx != LAST_IDX) begin
          wr_idx_nxt = wr_idx + 1'b1;
        end
      end

      S_W2R: begin
        if (lines_done == num_q) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          op_nxt    = OP_READ;
          addr_nxt  = src_q + line_offset;
          state_nxt = S_RD;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_loopback_seq.sv
// tb_loopback_seq: self-checking bench for loopback_seq. A small memory-controller
// model serves reads from / writes into an associative line memory; a line-level
// reference model predicts the address sequence, destination contents and err.
module tb_loopback_seq;

  localparam int WS   = 32;
  localparam int CLW  = 512;
  localparam int AW   = 64;
  localparam int FILL = CLW / WS;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [AW-1:0]  src_base, dst_base;
  logic [15:0]    num_lines;
  logic           busy, done, err;
  logic [15:0]    lines_done;
  logic           mc_ready, mc_rd_valid, mc_tx_done;
  logic [WS-1:0]  mc_rd_word;
  logic [1:0]     mc_op;
  logic [AW-1:0]  mc_raw_address;
  logic [WS-1:0]  mc_wr_word;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CLW-1:0] mem     [logic [AW-1:0]];
  logic [CLW-1:0] exp_mem [logic [AW-1:0]];
  logic [AW-1:0]  addr_log[$];
  logic [1:0]     op_log[$];
  logic [AW-1:0]  exp_addr[$];
  logic [WS-1:0]  model_buf [FILL];

  int            ctl_phase, ctl_cnt, ctl_k, ctl_len;
  int            ctl_reads = 0;
  int            short_line = -1;
  int            host_dly_max = 2;
  int            bubble_max = 2;
  int            ctl_addr_bad = 0;
  logic [AW-1:0] ctl_a;

  loopback_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(src_base), .dst_base(dst_base), .num_lines(num_lines),
    .busy(busy), .done(done), .err(err), .lines_done(lines_done),
    .mc_ready(mc_ready), .mc_rd_valid(mc_rd_valid), .mc_tx_done(mc_tx_done),
    .mc_rd_word(mc_rd_word), .mc_op(mc_op), .mc_raw_address(mc_raw_address),
    .mc_wr_word(mc_wr_word)
  );

  always #5 clk = ~clk;

  // Memory controller model: accepts an op when it sees READ/WRITE while idle,
  // streams/collects FILL words, pulses mc_tx_done, then waits for mc_op to idle.
  initial begin : ctrl_model
    logic [CLW-1:0] line;
    ctl_phase = 0; ctl_cnt = 0; ctl_k = 0; ctl_len = FILL; ctl_a = '0; line = '0;
    mc_rd_valid = 1'b0; mc_tx_done = 1'b0; mc_rd_word = '0;
    forever begin
      @(negedge clk);
      mc_rd_valid = 1'b0;
      mc_tx_done  = 1'b0;
      if (rst) begin
        ctl_phase = 0;
      end else begin
        if (ctl_phase >= 1 && ctl_phase <= 4 && mc_raw_address !== ctl_a) ctl_addr_bad++;
        case (ctl_phase)
          0: begin
            if (mc_op == 2'b01 || mc_op == 2'b11) begin
              ctl_a = mc_raw_address;
              addr_log.push_back(mc_raw_address);
              op_log.push_back(mc_op);
              ctl_k = 0;
              if (mc_op == 2'b01) begin
                ctl_len = (ctl_reads == short_line) ? 8 : FILL;
                ctl_reads++;
                ctl_cnt = $urandom_range(host_dly_max, 0);
                ctl_phase = 1;
              end else begin
                ctl_phase = 3;
              end
            end
          end
          1: begin
            if (ctl_cnt > 0) begin
              ctl_cnt--;
            end else begin
              line = mem.exists(ctl_a) ? mem[ctl_a] : '0;
              mc_rd_valid = 1'b1;
              mc_rd_word  = line[ctl_k*WS +: WS];
              mc_tx_done  = (ctl_k == ctl_len - 1);
              ctl_k++;
              if (ctl_k == ctl_len) ctl_phase = 5;
            end
          end
          3: begin
            line = mem.exists(ctl_a) ? mem[ctl_a] : '0;
            line[ctl_k*WS +: WS] = mc_wr_word;
            mem[ctl_a] = line;
            ctl_k++;
            if (ctl_k == FILL) begin
              ctl_cnt = $urandom_range(bubble_max, 0);
              ctl_phase = 4;
            end
          end
          4: begin
            if (ctl_cnt > 0) ctl_cnt--;
            else begin
              mc_tx_done = 1'b1;
              ctl_phase = 5;
            end
          end
          5: if (mc_op == 2'b00) ctl_phase = 0;
          default: ctl_phase = 0;
        endcase
      end
    end
  end

  // Reference model: line-by-line copy through a persistent line buffer.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input int short_idx);
    logic [CLW-1:0] line;
    logic [AW-1:0]  sa, da;
    exp_addr.delete();
    exp_mem = mem;
    for (int i = 0; i < n; i++) begin
      sa = s + 64'(i);
      da = d + 64'(i);
      exp_addr.push_back(sa);
      exp_addr.push_back(da);
      line = exp_mem.exists(sa) ? exp_mem[sa] : '0;
      for (int k = 0; k < ((i == short_idx) ? 8 : FILL); k++) model_buf[k] = line[k*WS +: WS];
      for (int k = 0; k < FILL; k++) line[k*WS +: WS] = model_buf[k];
      exp_mem[da] = line;
    end
  endtask

  task automatic seed_line(input logic [AW-1:0] a);
    logic [CLW-1:0] line;
    for (int k = 0; k < FILL; k++) line[k*WS +: WS] = $urandom;
    mem[a] = line;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    addr_log.delete();
    op_log.delete();
    ctl_reads = 0;
    src_base  = s;
    dst_base  = d;
    num_lines = 16'(n);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out, output int dones);
    timed_out = 1'b1;
    dones = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!timed_out) begin
      dones = 1;
      repeat (4) begin
        @(negedge clk);
        if (done === 1'b1) dones++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < FILL; k++) model_buf[k] = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mc_op !== 2'b00) begin n_bad++; $display("[TB] FAIL reset mc_op: got %b expected 00", mc_op); end
    n_cmp++; if (mc_raw_address !== 64'd0) begin n_bad++; $display("[TB] FAIL reset mc_raw_address: got %0h expected 0", mc_raw_address); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset err: got %b expected 0", err); end
    n_cmp++; if (lines_done !== 16'd0) begin n_bad++; $display("[TB] FAIL reset lines_done: got %0d expected 0", lines_done); end
    n_cmp++; if (mc_wr_word !== 32'd0) begin n_bad++; $display("[TB] FAIL reset mc_wr_word: got %0h expected 0", mc_wr_word); end
    do_reset();
  endtask

  task automatic test_single_line();
    bit to; int dn;
    logic [CLW-1:0] got;
    logic [CLW-1:0] line;
    for (int k = 0; k < FILL; k++) line[k*WS +: WS] = 32'h1000 + 32'(k);
    mem[64'h10] = line;
    model_copy(64'h10, 64'h80, 1, -1);
    applyStimulus(64'h10, 64'h80, 1);
    wait_done(400, to, dn);
    n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL single timeout: got no done expected done"); end
    n_cmp++; if (dn != 1) begin n_bad++; $display("[TB] FAIL single done_count: got %0d expected 1", dn); end
    got = mem.exists(64'h80) ? mem[64'h80] : '0;
    n_cmp++; if (got !== line) begin n_bad++; $display("[TB] FAIL single dst_line: got %0h expected %0h", got, line); end
    n_cmp++; if (lines_done !== 16'd1) begin n_bad++; $display("[TB] FAIL single lines_done: got %0d expected 1", lines_done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL single err: got %b expected 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single busy: got %b expected 0", busy); end
    n_cmp++; if (addr_log.size() != 2 || addr_log[0] !== 64'h10 || addr_log[1] !== 64'h80)
      begin n_bad++; $display("[TB] FAIL single addresses: got %p expected '{10,80}", addr_log); end
  endtask

  task automatic test_multi_line();
    bit to; int dn;
    logic [CLW-1:0] got;
    for (int i = 0; i < 3; i++) seed_line(64'(i));
    model_copy(64'h0, 64'h100, 3, -1);
    applyStimulus(64'h0, 64'h100, 3);
    repeat (30) @(negedge clk);
    // start while busy must be ignored
    src_base = 64'h999; dst_base = 64'h777; num_lines = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(800, to, dn);
    n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL multi timeout: got no done expected done"); end
    n_cmp++; if (lines_done !== 16'd3) begin n_bad++; $display("[TB] FAIL multi lines_done: got %0d expected 3", lines_done); end
    n_cmp++; if (addr_log.size() != exp_addr.size()) begin n_bad++; $display("[TB] FAIL multi addr_count: got %0d expected %0d", addr_log.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
      n_cmp++; if (addr_log[i] !== exp_addr[i] || op_log[i] !== ((i % 2 == 0) ? 2'b01 : 2'b11))
        begin n_bad++; $display("[TB] FAIL multi addr[%0d]: got %0h op %b expected %0h", i, addr_log[i], op_log[i], exp_addr[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      got = mem.exists(64'h100 + 64'(i)) ? mem[64'h100 + 64'(i)] : '0;
      n_cmp++; if (got !== exp_mem[64'h100 + 64'(i)]) begin n_bad++; $display("[TB] FAIL multi dst_line[%0d]: got %0h expected %0h", i, got, exp_mem[64'h100 + 64'(i)]); end
    end
  endtask

  task automatic test_zero_lines();
    bit bad_op, bad_busy, bad_done;
    bad_op = 0; bad_busy = 0; bad_done = 0;
    applyStimulus(64'h40, 64'h50, 0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL zero done_pulse: got %b expected 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL zero busy_at_done: got %b expected 0", busy); end
    repeat (10) begin
      @(negedge clk);
      if (mc_op !== 2'b00) bad_op = 1;
      if (busy !== 1'b0) bad_busy = 1;
      if (done !== 1'b0) bad_done = 1;
    end
    n_cmp++; if (bad_op || addr_log.size() != 0) begin n_bad++; $display("[TB] FAIL zero mc_op_activity: got %0d ops expected 0", addr_log.size()); end
    n_cmp++; if (bad_busy) begin n_bad++; $display("[TB] FAIL zero busy: got 1 expected 0"); end
    n_cmp++; if (bad_done) begin n_bad++; $display("[TB] FAIL zero extra_done: got 1 expected 0"); end
    n_cmp++; if (lines_done !== 16'd0) begin n_bad++; $display("[TB] FAIL zero lines_done: got %0d expected 0", lines_done); end
  endtask

  task automatic test_not_ready();
    bit to, bad_op, bad_busy; int dn;
    logic [CLW-1:0] got;
    bad_op = 0; bad_busy = 0;
    for (int i = 0; i < 2; i++) seed_line(64'h200 + 64'(i));
    model_copy(64'h200, 64'h300, 2, -1);
    mc_ready = 1'b0;
    applyStimulus(64'h200, 64'h300, 2);
    repeat (20) begin
      if (mc_op !== 2'b00) bad_op = 1;
      if (busy !== 1'b1) bad_busy = 1;
      @(negedge clk);
    end
    n_cmp++; if (bad_op) begin n_bad++; $display("[TB] FAIL notready mc_op: got non-idle expected 00"); end
    n_cmp++; if (bad_busy) begin n_bad++; $display("[TB] FAIL notready busy: got 0 expected 1"); end
    mc_ready = 1'b1;
    wait_done(800, to, dn);
    n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL notready timeout: got no done expected done"); end
    for (int i = 0; i < 2; i++) begin
      got = mem.exists(64'h300 + 64'(i)) ? mem[64'h300 + 64'(i)] : '0;
      n_cmp++; if (got !== exp_mem[64'h300 + 64'(i)]) begin n_bad++; $display("[TB] FAIL notready dst_line[%0d]: got %0h expected %0h", i, got, exp_mem[64'h300 + 64'(i)]); end
    end
  endtask

  task automatic test_short_read();
    bit to; int dn;
    logic [CLW-1:0] got;
    for (int i = 0; i < 3; i++) seed_line(64'h400 + 64'(i));
    seed_line(64'h480);
    short_line = 1;
    model_copy(64'h400, 64'h500, 3, 1);
    applyStimulus(64'h400, 64'h500, 3);
    wait_done(800, to, dn);
    short_line = -1;
    n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL short timeout: got no done expected done"); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL short err_sticky: got %b expected 1", err); end
    n_cmp++; if (lines_done !== 16'd3) begin n_bad++; $display("[TB] FAIL short lines_done: got %0d expected 3", lines_done); end
    for (int i = 0; i < 3; i++) begin
      got = mem.exists(64'h500 + 64'(i)) ? mem[64'h500 + 64'(i)] : '0;
      n_cmp++; if (got !== exp_mem[64'h500 + 64'(i)]) begin n_bad++; $display("[TB] FAIL short dst_line[%0d]: got %0h expected %0h", i, got, exp_mem[64'h500 + 64'(i)]); end
    end
    model_copy(64'h480, 64'h580, 1, -1);
    applyStimulus(64'h480, 64'h580, 1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL short err_clear: got %b expected 0", err); end
    wait_done(400, to, dn);
    n_cmp++; if (to || err !== 1'b0) begin n_bad++; $display("[TB] FAIL short clean_copy: got err %b timeout %b expected 0 0", err, to); end
  endtask

  task automatic test_reset_mid();
    bit found, to; int dn;
    logic [CLW-1:0] got;
    found = 0;
    for (int i = 0; i < 4; i++) seed_line(64'h600 + 64'(i));
    applyStimulus(64'h600, 64'h700, 4);
    for (int i = 0; i < 2000; i++) begin
      if (lines_done == 16'd1 && mc_op == 2'b11) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!found) begin n_bad++; $display("[TB] FAIL rstmid reach_wr: got not reached expected line2 WR"); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mc_op !== 2'b00 || mc_raw_address !== 64'd0) begin n_bad++; $display("[TB] FAIL rstmid mc_outputs: got op %b addr %0h expected 00 0", mc_op, mc_raw_address); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("[TB] FAIL rstmid flags: got busy %b done %b err %b expected 0 0 0", busy, done, err); end
    n_cmp++; if (lines_done !== 16'd0 || mc_wr_word !== 32'd0) begin n_bad++; $display("[TB] FAIL rstmid state: got lines %0d wr_word %0h expected 0 0", lines_done, mc_wr_word); end
    do_reset();
    for (int i = 0; i < 2; i++) seed_line(64'h800 + 64'(i));
    model_copy(64'h800, 64'h900, 2, -1);
    applyStimulus(64'h800, 64'h900, 2);
    wait_done(800, to, dn);
    n_cmp++; if (to || dn != 1) begin n_bad++; $display("[TB] FAIL rstmid recopy_done: got timeout %b dones %0d expected 0 1", to, dn); end
    for (int i = 0; i < 2; i++) begin
      got = mem.exists(64'h900 + 64'(i)) ? mem[64'h900 + 64'(i)] : '0;
      n_cmp++; if (got !== exp_mem[64'h900 + 64'(i)]) begin n_bad++; $display("[TB] FAIL rstmid dst_line[%0d]: got %0h expected %0h", i, got, exp_mem[64'h900 + 64'(i)]); end
    end
  endtask

  task automatic test_random();
    bit to; int dn, n;
    logic [AW-1:0] s, d;
    logic [CLW-1:0] got;
    ctl_addr_bad = 0;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(4, 1);
      s = (it == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
      d = s ^ 64'h4000_0000_0000_0000;
      host_dly_max = $urandom_range(3, 0);
      bubble_max = $urandom_range(3, 0);
      for (int i = 0; i < n; i++) seed_line(s + 64'(i));
      model_copy(s, d, n, -1);
      applyStimulus(s, d, n);
      wait_done(1500, to, dn);
      n_cmp++; if (to || dn != 1) begin n_bad++; $display("[TB] FAIL random[%0d] done: got timeout %b dones %0d expected 0 1", it, to, dn); end
      n_cmp++; if (lines_done !== 16'(n)) begin n_bad++; $display("[TB] FAIL random[%0d] lines_done: got %0d expected %0d", it, lines_done, n); end
      n_cmp++; if (addr_log.size() != exp_addr.size()) begin n_bad++; $display("[TB] FAIL random[%0d] addr_count: got %0d expected %0d", it, addr_log.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
        n_cmp++; if (addr_log[i] !== exp_addr[i]) begin n_bad++; $display("[TB] FAIL random[%0d] addr[%0d]: got %0h expected %0h", it, i, addr_log[i], exp_addr[i]); end
      end
      for (int i = 0; i < n; i++) begin
        got = mem.exists(d + 64'(i)) ? mem[d + 64'(i)] : '0;
        n_cmp++; if (got !== exp_mem[d + 64'(i)]) begin n_bad++; $display("[TB] FAIL random[%0d] dst_line[%0d]: got %0h expected %0h", it, i, got, exp_mem[d + 64'(i)]); end
      end
    end
    n_cmp++; if (ctl_addr_bad != 0) begin n_bad++; $display("[TB] FAIL random addr_stable: got %0d changes expected 0", ctl_addr_bad); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; num_lines = '0; mc_ready = 1'b1;
    $display("[TB] starting loopback_seq bench");
    test_reset();
    test_single_line();
    test_multi_line();
    test_zero_lines();
    test_not_ready();
    test_short_read();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
